// File: rtl/pixel_stream_packer.sv
// ============================================================================
// Module   : pixel_stream_packer
// Purpose  : Packs 24-bit RGB pixels into 32-bit little-endian AXI4-Stream
//            words (4 pixels -> 3 words), flushing a padded word at end of line.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pixel_stream_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_red,
    input  logic [7:0]  in_green,
    input  logic [7:0]  in_blue,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic        in_ready,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tuser,
    output logic        out_tlast,
    output logic        align_err
);

    typedef enum logic [0:0] {
        ST_PACK  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] c_phase_zero = 2'd0;

    state_t      state_q,      state_d;
    logic [1:0]  phase_q,      phase_d;
    logic [23:0] res_q,        res_d;
    logic [31:0] pend_q,       pend_d;
    logic        sof_pend_q,   sof_pend_d;
    logic        align_err_q,  align_err_d;
    logic [31:0] out_tdata_q,  out_tdata_d;
    logic        out_tvalid_q, out_tvalid_d;
    logic        out_tuser_q,  out_tuser_d;
    logic        out_tlast_q,  out_tlast_d;

    logic [23:0] w_pixel;
    logic        w_out_free;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_load;
    logic [31:0] w_load_data;
    logic        w_load_last;

    assign w_pixel    = {in_red, in_green, in_blue};
    assign w_out_free = !out_tvalid_q || out_tready;
    assign w_in_ready = !reset && (state_q == ST_PACK) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        res_d        = res_q;
        pend_d       = pend_q;
        sof_pend_d   = sof_pend_q;
        align_err_d  = align_err_q;
        out_tdata_d  = out_tdata_q;
        out_tuser_d  = out_tuser_q;
        out_tlast_d  = out_tlast_q;
        out_tvalid_d = out_tvalid_q && !out_tready;
        w_load       = 1'b0;
        w_load_data  = 32'h0;
        w_load_last  = 1'b0;

        unique case (state_q)
            ST_PACK: begin
                if (w_accept) begin
                    if (in_sof) begin
                        sof_pend_d = 1'b1;
                        if (phase_q != c_phase_zero) begin
                            align_err_d = 1'b1;
                        end
                    end
                    unique case (phase_q)
                        2'd0: begin
                            res_d   = w_pixel;
                            phase_d = 2'd1;
                            if (in_eol) begin
                                w_load      = 1'b1;
                                w_load_data = {PAD_BYTE, w_pixel};
                                w_load_last = 1'b1;
                                phase_d     = c_phase_zero;
                            end
                        end
                        2'd1: begin
                            w_load      = 1'b1;
                            w_load_data = {w_pixel[7:0], res_q};
                            res_d       = {8'h00, w_pixel[23:8]};
                            phase_d     = 2'd2;
                            if (in_eol) begin
                                pend_d  = {PAD_BYTE, PAD_BYTE, w_pixel[23:8]};
                                state_d = ST_FLUSH;
                                phase_d = c_phase_zero;
                            end
                        end
                        2'd2: begin
                            w_load      = 1'b1;
                            w_load_data = {w_pixel[15:0], res_q[15:0]};
                            res_d       = {16'h0000, w_pixel[23:16]};
                            phase_d     = 2'd3;
                            if (in_eol) begin
                                pend_d  = {PAD_BYTE, PAD_BYTE, PAD_BYTE, w_pixel[23:16]};
                                state_d = ST_FLUSH;
                                phase_d = c_phase_zero;
                            end
                        end
                        default: begin
                            w_load      = 1'b1;
                            w_load_data = {w_pixel, res_q[7:0]};
                            w_load_last = in_eol;
                            phase_d     = c_phase_zero;
                        end
                    endcase
                end
            end
            ST_FLUSH: begin
                // Upstream is held off here, so the pending word only waits for room
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = pend_q;
                    w_load_last = 1'b1;
                    state_d     = ST_PACK;
                    phase_d     = c_phase_zero;
                end
            end
            default: begin
                state_d = ST_PACK;
            end
        endcase

        // The word that includes a SOF pixel's bytes carries tuser as well
        if (w_load) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = w_load_data;
            out_tlast_d  = w_load_last;
            out_tuser_d  = sof_pend_d;
            sof_pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PACK;
            phase_q      <= c_phase_zero;
            res_q        <= 24'h0;
            pend_q       <= 32'h0;
            sof_pend_q   <= 1'b0;
            align_err_q  <= 1'b0;
            out_tdata_q  <= 32'h0;
            out_tvalid_q <= 1'b0;
            out_tuser_q  <= 1'b0;
            out_tlast_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            res_q        <= res_d;
            pend_q       <= pend_d;
            sof_pend_q   <= sof_pend_d;
            align_err_q  <= align_err_d;
            out_tdata_q  <= out_tdata_d;
            out_tvalid_q <= out_tvalid_d;
            out_tuser_q  <= out_tuser_d;
            out_tlast_q  <= out_tlast_d;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_tdata  = out_tdata_q;
    assign out_tvalid = out_tvalid_q;
    assign out_tuser  = out_tuser_q;
    assign out_tlast  = out_tlast_q;
    assign align_err  = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_packer.sv
// ============================================================================
// Module   : tb_pixel_stream_packer
// Purpose  : Self-checking bench for pixel_stream_packer: byte-queue model,
//            per-cycle compare process and directed literal scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_stream_packer;

    localparam logic [7:0] c_pad = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_red, in_green, in_blue;
    logic        in_valid, in_sof, in_eol, in_ready;
    logic [31:0] out_tdata;
    logic        out_tvalid, out_tready, out_tuser, out_tlast, align_err;

    always #5 clk = ~clk;

    pixel_stream_packer #(.PAD_BYTE(c_pad)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_red     (in_red),
        .in_green   (in_green),
        .in_blue    (in_blue),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eol     (in_eol),
        .in_ready   (in_ready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tuser  (out_tuser),
        .out_tlast  (out_tlast),
        .align_err  (align_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(string name, logic ok, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endfunction

    // Model: bytes of the current line in arrival order; words are {tuser,tlast,tdata}
    logic [7:0]  bq[$];
    logic [33:0] exp_q[$];
    logic [33:0] log_q[$];
    bit          sof_m;
    bit          align_m;
    int          line_pix;

    function automatic void model_reset();
        bq.delete();
        exp_q.delete();
        sof_m    = 1'b0;
        align_m  = 1'b0;
        line_pix = 0;
    endfunction

    function automatic void emit(bit last);
        logic [31:0] w;
        w = {bq[3], bq[2], bq[1], bq[0]};
        repeat (4) void'(bq.pop_front());
        exp_q.push_back({sof_m, last, w});
        sof_m = 1'b0;
    endfunction

    function automatic void model_push(logic [23:0] p, logic sof, logic eol);
        bq.push_back(p[7:0]);
        bq.push_back(p[15:8]);
        bq.push_back(p[23:16]);
        if (sof) begin
            if (line_pix != 0) align_m = 1'b1;
            sof_m = 1'b1;
        end
        while (bq.size() >= 4) emit(eol && (bq.size() == 4));
        if (eol && bq.size() > 0) begin
            while (bq.size() < 4) bq.push_back(c_pad);
            emit(1'b1);
        end
        line_pix = eol ? 0 : (line_pix + 1) % 4;
    endfunction

    // Sink ready pattern: 0 always 1, 1 toggling 1,0,0,1, 2 random, 3 always 0
    int mode    = 0;
    int pat_idx = 0;
    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_tready = 1'b1;
            1: out_tready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
            2: out_tready = ($urandom_range(2) != 0);
            default: out_tready = 1'b0;
        endcase
        pat_idx++;
    end

    bit          chk_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_word;
    int          rdy_low_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                model_reset();
                prev_stall = 1'b0;
                check("in_ready during reset", in_ready === 1'b0, in_ready, 0);
            end else begin
                check("align_err", align_err === align_m, align_err, align_m);
                if (prev_stall)
                    check("held word", {out_tvalid, out_tuser, out_tlast, out_tdata} === {1'b1, prev_word},
                          {out_tvalid, out_tuser, out_tlast, out_tdata}, {1'b1, prev_word});
                if (out_tvalid && !out_tready)
                    check("in_ready while stalled", in_ready === 1'b0, in_ready, 0);
                if (in_valid && in_ready)
                    model_push({in_red, in_green, in_blue}, in_sof, in_eol);
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected word", 1'b0, {out_tuser, out_tlast, out_tdata}, 0);
                    end else begin
                        logic [33:0] e;
                        e = exp_q.pop_front();
                        check("word {tuser,tlast,tdata}", {out_tuser, out_tlast, out_tdata} === e,
                              {out_tuser, out_tlast, out_tdata}, e);
                    end
                    log_q.push_back({out_tuser, out_tlast, out_tdata});
                end
                if (in_ready !== 1'b1) rdy_low_cnt++;
                prev_stall = out_tvalid && !out_tready;
                prev_word  = {out_tuser, out_tlast, out_tdata};
            end
        end
    end

    task automatic send(logic [23:0] p, logic sof, logic eol);
        int t = 0;
        {in_red, in_green, in_blue} = p;
        in_sof   = sof;
        in_eol   = eol;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check("send timeout", 1'b0, t, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_tvalid === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain in time", t < 500, t, 500);
        check("model empty", exp_q.size() == 0, exp_q.size(), 0);
        idle(1);
    endtask

    task automatic chk_log(int i, logic [33:0] req, string name);
        if (i < log_q.size()) check(name, log_q[i] === req, log_q[i], req);
        else check(name, 1'b0, 0, req);
    endtask

    task automatic chk_reset_vals();
        check("reset tvalid", out_tvalid === 1'b0, out_tvalid, 0);
        check("reset tdata", out_tdata === 32'h0, out_tdata, 0);
        check("reset tuser/tlast", {out_tuser, out_tlast} === 2'b00, {out_tuser, out_tlast}, 0);
        check("reset align_err", align_err === 1'b0, align_err, 0);
        check("reset in_ready", in_ready === 1'b0, in_ready, 0);
    endtask

    task automatic aligned_line(logic eol_last);
        send(24'hAABBCC, 1'b1, 1'b0);
        send(24'h112233, 1'b0, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, eol_last);
    endtask

    task automatic chk_aligned_words(logic last3);
        chk_log(0, {1'b1, 1'b0, 32'h33AABBCC}, "aligned w0");
        chk_log(1, {1'b0, 1'b0, 32'h55661122}, "aligned w1");
        chk_log(2, {1'b0, last3, 32'h77889944}, "aligned w2");
    endtask

    initial begin
        reset = 1'b1;
        {in_red, in_green, in_blue} = 24'h0;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        out_tready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", in_ready === 1'b1, in_ready, 1);
        @(posedge clk); #1;

        // Aligned line, full throughput
        log_q.delete(); rdy_low_cnt = 0;
        aligned_line(1'b1);
        drain();
        check("aligned count", log_q.size() == 3, log_q.size(), 3);
        chk_aligned_words(1'b1);
        check("aligned in_ready low cycles", rdy_low_cnt == 0, rdy_low_cnt, 0);

        // Width 5
        log_q.delete(); rdy_low_cnt = 0;
        aligned_line(1'b0);
        send(24'hDDEEFF, 1'b0, 1'b1);
        drain();
        chk_aligned_words(1'b0);
        chk_log(3, {1'b0, 1'b1, 32'h00DDEEFF}, "width5 w3");
        check("width5 in_ready low cycles", rdy_low_cnt == 0, rdy_low_cnt, 0);

        // Width 6 with flush
        log_q.delete(); rdy_low_cnt = 0;
        aligned_line(1'b0);
        send(24'hDDEEFF, 1'b0, 1'b0);
        send(24'h010203, 1'b0, 1'b1);
        drain();
        chk_log(3, {1'b0, 1'b0, 32'h03DDEEFF}, "width6 w3");
        chk_log(4, {1'b0, 1'b1, 32'h00000102}, "width6 flush word");
        check("width6 in_ready low cycles", rdy_low_cnt == 1, rdy_low_cnt, 1);

        // Backpressure 1,0,0,1
        log_q.delete(); mode = 1;
        aligned_line(1'b1);
        drain();
        mode = 0;
        chk_aligned_words(1'b1);

        // SOF on the second pixel
        log_q.delete();
        send(24'hAABBCC, 1'b0, 1'b0);
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b1);
        drain();
        chk_log(0, {1'b1, 1'b0, 32'h33AABBCC}, "misaligned sof w0");
        check("align_err set", align_err === 1'b1, align_err, 1);
        log_q.delete();
        aligned_line(1'b1);
        drain();
        idle(5);
        check("align_err sticky", align_err === 1'b1, align_err, 1);

        // Reset after two pixels, word stuck in the output register
        mode = 3;
        idle(1);
        send(24'h123456, 1'b1, 1'b0);
        send(24'h789ABC, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        mode = 0;
        @(negedge clk);
        check("in_ready after mid reset", in_ready === 1'b1, in_ready, 1);
        @(posedge clk); #1;
        log_q.delete();
        aligned_line(1'b1);
        drain();
        check("post-reset count", log_q.size() == 3, log_q.size(), 3);
        chk_aligned_words(1'b1);

        // Randomized traffic against the model
        mode = 2;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            send(24'($urandom), ($urandom_range(15) == 0), (i == 799) || ($urandom_range(4) == 0));
        end
        drain();
        mode = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_stream_packer.md
# pixel_stream_packer

Packs the 24-bit RGB pixel stream leaving the ray-tracing unit into 32-bit AXI4-Stream words for the video DMA. Four pixels become three words, and a partial word is flushed at every end of line. Frame and line markers (SOF/EOL) map to AXI `tuser`/`tlast`. The block sits directly downstream of the ray-tracing unit and drives that unit's external ready.

## Interface
- PAD_BYTE, default 8'h00: byte value used to fill unused bytes of a flushed partial word.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_red / in_green / in_blue  in  8 each  pixel colour; pixel P = {red, green, blue}, so P[7:0] is blue.
- in_valid  in  1  pixel valid.
- in_sof  in  1  pixel is the first of a frame.
- in_eol  in  1  pixel is the last of a line.
- in_ready  out  1  block accepts the pixel this cycle; connects to the upstream external ready.
- out_tdata  out  32  packed word, little-endian byte order.
- out_tvalid  out  1  AXI-Stream valid.
- out_tready  in  1  AXI-Stream ready.
- out_tuser  out  1  first word of a frame.
- out_tlast  out  1  last word of a line.
- align_err  out  1  sticky flag: in_sof arrived with phase != 0; cleared only by reset.

## Operation
- A pixel is accepted when in_valid && in_ready.
- phase (2 bits) counts accepted pixels within the current 4-pixel group.
- Residual register R holds leftover bytes (24/16/8 bits) from earlier pixels.
- States are PACK and FLUSH.

**PACK, accepted pixel P:**
- phase 0: R <= P; no output. If in_eol: emit {PAD_BYTE, P} with tlast=1; phase stays 0.
- phase 1: emit {P[7:0], R[23:0]}; R <= P[23:8]. If in_eol: go to FLUSH with pending word {2×PAD_BYTE, P[23:8]}.
- phase 2: emit {P[15:0], R[15:0]}; R <= P[23:16]. If in_eol: go to FLUSH with pending word {3×PAD_BYTE, P[23:16]}.
- phase 3: emit {P[23:0], R[7:0]}; phase <= 0. If in_eol: tlast=1 on this word.
- Otherwise phase <= phase+1 (wrapping 3→0). Any in_eol returns phase to 0.

**FLUSH:**
- in_ready=0.
- When the output register is free, load the pending word with tlast=1; next state is PACK with phase 0.

**SOF / tuser:**
- An accepted pixel with in_sof sets sof_pend.
- The next word loaded into the output register carries tuser=sof_pend, then sof_pend clears.
- in_sof at phase != 0 sets align_err and packing continues unchanged.

**Output register:**
- Single entry.
- Cleared (out_tvalid <= 0) on out_tvalid && out_tready with no new load.
- A load and a drain in the same cycle are both allowed.

**in_ready:**
- in_ready = !reset && state==PACK && (!out_tvalid || out_tready). This is combinational from registers and out_tready.

## Timing
- Reset values: out_tvalid=0, out_tdata=0, out_tuser=0, out_tlast=0, align_err=0, phase=0, state=PACK, sof_pend=0, R=0. in_ready=0 while reset is high and 1 on the first cycle after.
- Latency: a word produced by a pixel accepted at edge n is valid (out_tvalid=1) after edge n.
- Full throughput: with out_tready held at 1, one pixel is accepted per cycle. FLUSH costs exactly one extra cycle per line whose width mod 4 ∈ {2,3}.
- Backpressure: out_tdata, out_tuser and out_tlast stay stable while out_tvalid && !out_tready. No pixel is accepted during that time.
- Reset mid-line: all residual and pending data is discarded; the first pixel after reset packs at phase 0.
- Words leave in strict input order and no word is ever dropped or duplicated.

## Test plan
- **Aligned line:** pixels 0xAABBCC(sof), 0x112233, 0x445566, 0x778899(eol), out_tready=1.
  - Required words: 0x33AABBCC (tuser=1), 0x55661122, 0x77889944 (tlast=1).
  - in_ready stays 1 throughout.
- **Width 5:** the aligned line with eol moved to a fifth pixel 0xDDEEFF.
  - Fourth word must be 0x00DDEEFF with tlast=1.
- **Width 6 flush:** fifth pixel 0xDDEEFF, sixth pixel 0x010203 (eol).
  - Required words: 0x03DDEEFF (tlast=0), then 0x00000102 (tlast=1).
  - in_ready=0 for exactly one cycle.
- **Backpressure:** aligned line with out_tready toggling 1,0,0,1 repeatedly.
  - Same three words, each held stable while stalled.
  - in_ready=0 on every stalled cycle with out_tvalid=1.
- **Misaligned sof:** in_sof on the second pixel of a line.
  - align_err=1 and stays 1 until reset.
  - tuser=1 on the next emitted word.
- **Reset mid-group:** assert reset after two pixels are accepted.
  - All outputs return to reset values.
  - A new aligned line then yields the exact words of the aligned-line scenario.
